// File: rtl/dahb_master_if.sv
// dahb_master_if: AHB-Lite bus bundle between dahb_master and its slave
//
// Signals:
//   HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA : master -> slave
//   HRDATA, HREADY, HRESP                               : slave -> master
// Modports:
//   master : driven by dahb_master
//   slave  : seen by the bus slave / interconnect
interface dahb_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/dahb_master.sv
// dahb_master: buffered CPU data-side AHB-Lite master issuing SINGLE transfers in order
//
// Parameters:
//   BUF_DEPTH : command-buffer entries (power of 2, 2..16)
// Ports:
//   cpu_clk, cpu_rstn         : clock (rising edge) and asynchronous active-low reset
//   DAHB_access               : push request from MEM stage
//   DAHB_rd0_wr1              : 0 read, 1 write
//   DAHB_size                 : AHB size code
//   DAHB_addr                 : access address
//   DAHB_write_data           : lane-placed write data
//   DAHB_trans_buffer_full    : buffer holds BUF_DEPTH entries
//   DAHB_read_data            : read return data (zero for an errored read)
//   DAHB_read_data_valid      : one-cycle read-return strobe
//   ahb                       : AHB-Lite master bus (dahb_master_if.master)
// Optional feature (macro KRV_DAHB_ERR_CAPTURE_EN):
//   DAHB_err_valid            : sticky flag, set on the first errored command
//   DAHB_err_addr             : address of that first errored command
module dahb_master #(
    parameter int BUF_DEPTH = 4
) (
    input  logic          cpu_clk,
    input  logic          cpu_rstn,
    input  logic          DAHB_access,
    input  logic          DAHB_rd0_wr1,
    input  logic [2:0]    DAHB_size,
    input  logic [31:0]   DAHB_addr,
    input  logic [31:0]   DAHB_write_data,
    output logic          DAHB_trans_buffer_full,
    output logic [31:0]   DAHB_read_data,
    output logic          DAHB_read_data_valid,
    dahb_master_if.master ahb
`ifdef KRV_DAHB_ERR_CAPTURE_EN
    ,
    output logic          DAHB_err_valid,
    output logic [31:0]   DAHB_err_addr
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    if (BUF_DEPTH < 2 || BUF_DEPTH > 16 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dahb_master: BUF_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_q, state_d;
    logic          buf_wr    [BUF_DEPTH];
    logic [2:0]    buf_size  [BUF_DEPTH];
    logic [31:0]   buf_addr  [BUF_DEPTH];
    logic [31:0]   buf_wdata [BUF_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, head;
    logic [CW-1:0] count;
    logic          push, pop, load;
    logic [31:0]   haddr_q, hwdata_q;
    logic          hwrite_q;
    logic [2:0]    hsize_q;

    assign DAHB_trans_buffer_full = (count == CW'(BUF_DEPTH));
    assign push = DAHB_access && !DAHB_trans_buffer_full;
    assign pop  = (state_q == DATA) && ahb.HREADY;
    // Entry that becomes the head after this edge; used when loading the next address phase.
    assign head = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign load = (state_d == ADDR) && (state_q != ADDR);

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            buf_wr[wr_ptr]    <= DAHB_rd0_wr1;
            buf_size[wr_ptr]  <= DAHB_size;
            buf_addr[wr_ptr]  <= DAHB_addr;
            buf_wdata[wr_ptr] <= DAHB_write_data;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Going back to ADDR straight from DATA needs an entry already stored behind the head;
    // an entry pushed in the same cycle is picked up one cycle later via IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (count != '0) ? ADDR : IDLE;
            ADDR:    state_d = ahb.HREADY ? DATA : ADDR;
            DATA:    state_d = !ahb.HREADY ? DATA : (count > CW'(1)) ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address-phase registers load only on entry to ADDR, so they hold through wait
    // states, the data phase and IDLE.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
        end else if (load) begin
            haddr_q  <= buf_addr[head];
            hwrite_q <= buf_wr[head];
            hsize_q  <= buf_size[head];
            hwdata_q <= buf_wdata[head];
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            DAHB_read_data       <= '0;
            DAHB_read_data_valid <= 1'b0;
        end else begin
            DAHB_read_data_valid <= pop && !hwrite_q;
            if (pop && !hwrite_q) DAHB_read_data <= ahb.HRESP ? 32'h0 : ahb.HRDATA;
        end
    end

`ifdef KRV_DAHB_ERR_CAPTURE_EN
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            DAHB_err_valid <= 1'b0;
            DAHB_err_addr  <= '0;
        end else if (pop && ahb.HRESP && !DAHB_err_valid) begin
            DAHB_err_valid <= 1'b1;
            DAHB_err_addr  <= haddr_q;
        end
    end
`else
    // Errored commands retire without a record; a failed read is visible only as zero data.
`endif

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = (state_q == ADDR) ? 2'b10 : 2'b00;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HSIZE  = hsize_q;
    assign ahb.HWDATA = hwdata_q;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = 4'b0011;

endmodule

// File: tb/tb_dahb_master.sv
// tb_dahb_master: directed and randomized check of dahb_master against a command-queue model
//
// The bench acts as CPU and as AHB slave. A queue holds the commands the buffer should
// contain; the head is matched against each address phase, write data is checked during
// the data phase, and a completed read predicts the next-cycle return strobe and data.
module tb_dahb_master;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn = 1'b1;
    logic        access = 1'b0, rd0_wr1 = 1'b0;
    logic [2:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        full, rvalid;
    logic [31:0] rdata;
`ifdef KRV_DAHB_ERR_CAPTURE_EN
    logic        err_valid;
    logic [31:0] err_addr;
`endif

    dahb_master_if bus ();

    dahb_master #(.BUF_DEPTH(DEPTH)) dut (
        .cpu_clk(cpu_clk),
        .cpu_rstn(cpu_rstn),
        .DAHB_access(access),
        .DAHB_rd0_wr1(rd0_wr1),
        .DAHB_size(size),
        .DAHB_addr(addr),
        .DAHB_write_data(wdata),
        .DAHB_trans_buffer_full(full),
        .DAHB_read_data(rdata),
        .DAHB_read_data_valid(rvalid),
        .ahb(bus)
`ifdef KRV_DAHB_ERR_CAPTURE_EN
        , .DAHB_err_valid(err_valid), .DAHB_err_addr(err_addr)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    cmd_t        q[$];
    bit          in_data, exp_valid;
    logic [31:0] exp_rdata;
    int          n_cmp, n_err;
    logic [1:0]  o_trans;
    logic [2:0]  o_size;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_full, o_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, drive inputs for the next edge, advance the model.
    task automatic cyc(input bit acc, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy, input bit resp, input logic [31:0] hr);
        cmd_t c;
        bit   was_full;
        @(negedge cpu_clk);
        o_trans = bus.HTRANS; o_addr = bus.HADDR; o_size = bus.HSIZE; o_wdata = bus.HWDATA;
        o_full = full; o_valid = rvalid; o_rdata = rdata;
        chk("rvalid", 32'(rvalid), 32'(exp_valid));
        if (exp_valid) chk("rdata", rdata, exp_rdata);
        was_full = (q.size() == DEPTH);
        chk("full", 32'(full), 32'(was_full));
        if (in_data) begin
            chk("trans_data", 32'(bus.HTRANS), 0);
            if (q[0].wr) chk("hwdata", bus.HWDATA, q[0].d);
        end else if (q.size() == 0) begin
            chk("trans_empty", 32'(bus.HTRANS), 0);
        end else if (bus.HTRANS == 2'b10) begin
            chk("haddr", bus.HADDR, q[0].a);
            chk("hwrite", 32'(bus.HWRITE), 32'(q[0].wr));
            chk("hsize", 32'(bus.HSIZE), 32'(q[0].sz));
            chk("hburst", 32'(bus.HBURST), 0);
            chk("hprot", 32'(bus.HPROT), 3);
        end else begin
            chk("trans_wait", 32'(bus.HTRANS), 0);
        end
        access = acc; rd0_wr1 = wr; size = sz; addr = a; wdata = d;
        bus.HREADY = rdy; bus.HRESP = resp; bus.HRDATA = hr;
        exp_valid = 1'b0;
        if (in_data && rdy) begin
            if (!q[0].wr) begin
                exp_valid = 1'b1;
                exp_rdata = resp ? 32'h0 : hr;
            end
            void'(q.pop_front());
            in_data = 1'b0;
        end else if (!in_data && o_trans == 2'b10 && rdy && q.size() != 0) begin
            in_data = 1'b1;
        end
        if (acc && !was_full) begin
            c.wr = wr; c.sz = sz; c.a = a; c.d = d;
            q.push_back(c);
        end
    endtask

    task automatic idle(input int n, input logic [31:0] hr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, hr);
    endtask

    task automatic do_reset();
        #2 cpu_rstn = 1'b0;
        #1;
        chk("rst_htrans", 32'(bus.HTRANS), 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwrite", 32'(bus.HWRITE), 0);
        chk("rst_hsize", 32'(bus.HSIZE), 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_full", 32'(full), 0);
`ifdef KRV_DAHB_ERR_CAPTURE_EN
        chk("rst_err_valid", 32'(err_valid), 0);
`endif
        q.delete();
        in_data = 1'b0;
        exp_valid = 1'b0;
        access = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        idle(2, 32'h0);

        // Single word read with zero wait states.
        cyc(1'b1, 1'b0, 3'b010, 32'h4000_0010, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r032_idle", 32'(o_trans), 0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        chk("r032_nonseq", 32'(o_trans), 2);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r032_valid", 32'(o_valid), 1);
        chk("r032_rdata", o_rdata, 32'hDEADBEEF);
        idle(2, 32'h0);

        // Fill the buffer while the bus stalls; the fifth access is dropped.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 3'b010, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 3'b010, 32'h110, 32'hBAD, 1'b0, 1'b0, 32'h0);
        chk("r033_full", 32'(o_full), 1);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("r033_head", o_addr, 32'h100);
        idle(16, 32'h0);

        // Byte write with address and data wait states.
        cyc(1'b1, 1'b1, 3'b000, 32'h203, 32'hAA00_0000, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r034_nonseq", 32'(o_trans), 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("r034_haddr", o_addr, 32'h203);
            chk("r034_hsize", 32'(o_size), 0);
            chk("r034_hwdata", o_wdata, 32'hAA00_0000);
        end
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(2, 32'h0);

        // Write then read to the same address, pushed back to back.
        cyc(1'b1, 1'b1, 3'b010, 32'h300, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        idle(8, 32'h5555_AAAA);

        // Errored read: HRESP high for two cycles.
        cyc(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r036_nonseq", 32'(o_trans), 2);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7777_7777);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("r036_valid", 32'(o_valid), 1);
        chk("r036_rdata", o_rdata, 32'h0);
`ifdef KRV_DAHB_ERR_CAPTURE_EN
        chk("r036_err_valid", 32'(err_valid), 1);
        chk("r036_err_addr", err_addr, 32'h500);
`endif
        idle(2, 32'h0);

        // Reset during the data phase of a read with two more commands queued.
        cyc(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 3'b010, 32'h604, 32'h6, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 3'b010, 32'h608, 32'h8, 1'b1, 1'b0, 32'h0);
        chk("r037_nonseq", 32'(o_trans), 2);
        cyc(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
        chk("r037_data_phase", 32'(o_trans), 0);
        do_reset();
        idle(6, 32'h1234_5678);

        // Randomized traffic, then drain.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                $urandom, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
        idle(40, 32'h0);
        chk("drain_left", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dahb_master.md
DAHB_MASTER -- requirements
Module: dahb_master

Interface
REQ-001 SHALL provide parameter BUF_DEPTH, default 4, command-buffer entries (power of 2, 2..16).
REQ-002 SHALL provide port cpu_clk  input  1  cpu clock (all logic rising-edge).
REQ-003 SHALL provide port cpu_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port DAHB_access  input  1  push request from MEM stage.
REQ-005 SHALL provide port DAHB_rd0_wr1  input  1  command type: 0 read, 1 write.
REQ-006 SHALL provide port DAHB_size  input  3  AHB size code: 000 byte, 001 half, 010 word.
REQ-007 SHALL provide port DAHB_addr  input  32  access address.
REQ-008 SHALL provide port DAHB_write_data  input  32  lane-placed write data.
REQ-009 SHALL provide port DAHB_trans_buffer_full  output  1  buffer holds BUF_DEPTH entries.
REQ-010 SHALL provide port DAHB_read_data  output  32  read return data.
REQ-011 SHALL provide port DAHB_read_data_valid  output  1  one-cycle read-return strobe.
REQ-012 SHALL provide ports HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HWDATA out 32 (AHB-Lite master).
REQ-013 SHALL provide ports HRDATA in 32, HREADY in 1, HRESP in 1.

Function
REQ-014 SHALL store {rd0_wr1, size, addr, wdata} in a FIFO on any cycle where DAHB_access=1 and DAHB_trans_buffer_full=0; access while full SHALL be dropped (upstream stalls).
REQ-015 DAHB_trans_buffer_full SHALL be decoded from the registered count (count==BUF_DEPTH); a same-cycle pop SHALL NOT admit a push while full.
REQ-016 Push to an empty buffer while IDLE SHALL reach the bus no earlier than the following cycle (registered address phase).
REQ-017 FSM states: IDLE, ADDR, DATA; IDLE->ADDR when count>0.
REQ-018 In ADDR: HTRANS=NONSEQ (2'b10), HADDR/HWRITE/HSIZE from FIFO head; ->DATA when HREADY=1, otherwise hold all address-phase outputs.
REQ-019 In DATA: HTRANS=IDLE, HWDATA = head write data (held stable); on HREADY=1 pop head, then ->ADDR if count after pop >0, else ->IDLE.
REQ-020 Commands SHALL complete strictly in FIFO order; a read SHALL never bypass an earlier buffered write.
REQ-021 Read completing (DATA, HREADY=1, HRESP=0) SHALL register HRDATA into DAHB_read_data and pulse DAHB_read_data_valid for exactly one cycle on the next cycle.
REQ-022 Write completion SHALL produce no read-valid pulse.
REQ-023 HRESP=1 with HREADY=0 SHALL keep HTRANS=IDLE and wait; on the final HREADY=1 the command SHALL retire; a failed read SHALL return DAHB_read_data=32'h0 with valid pulse (no deadlock).
REQ-024 HBURST SHALL be constant 3'b000 (SINGLE); HPROT constant 4'b0011 (non-cacheable privileged data).
REQ-025 Count SHALL be width clog2(BUF_DEPTH)+1; pointers SHALL wrap modulo BUF_DEPTH.
REQ-026 Simultaneous push and pop when not full SHALL leave count unchanged.
REQ-027 In IDLE HADDR, HWRITE, HSIZE, HWDATA SHALL hold last values.

Reset
REQ-028 Reset SHALL asynchronously clear FIFO pointers and count, enter IDLE, and drive HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b000, HWDATA=0, DAHB_read_data=0, DAHB_read_data_valid=0, DAHB_trans_buffer_full=0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered commands; no valid pulse SHALL follow deassertion.

Configuration
REQ-030 Macro KRV_DAHB_ERR_CAPTURE_EN defined SHALL add outputs DAHB_err_valid (1) and DAHB_err_addr (32): on first HRESP=1 completion capture HADDR of that command and set DAHB_err_valid sticky until reset; later errors SHALL NOT overwrite.
REQ-031 Without KRV_DAHB_ERR_CAPTURE_EN those ports and registers SHALL not exist; error behaviour otherwise per REQ-023.

Verification
REQ-032 Single word read addr 0x4000_0010, HRDATA=0xDEADBEEF, HREADY=1 -> NONSEQ one cycle, valid pulse with 0xDEADBEEF two cycles after ADDR.
REQ-033 Four pushed writes 0x100,0x104,0x108,0x10C with BUF_DEPTH=4, HREADY=0 -> full=1 after 4th push, 5th access dropped, bus order 0x100..0x10C after HREADY=1.
REQ-034 Byte write size=000 addr 0x203 data 0xAA00_0000, 3 wait states -> HSIZE=000, HADDR/HWDATA held stable across waits.
REQ-035 Write 0x300 then read 0x300 pushed back-to-back -> read NONSEQ only after write DATA completes; read returns HRDATA value.
REQ-036 Read 0x500 with HRESP=1 two cycles -> valid pulse with data 0x0; with macro DAHB_err_valid=1, DAHB_err_addr=0x500.
REQ-037 cpu_rstn low during DATA of a read with 2 commands queued -> all outputs at reset values, full=0, no valid pulse after release.
